// File: rtl/rr_req_arbiter4.sv
// Four-source round-robin arbiter: request pulses latch into sticky pending bits,
// and one-hot grants are issued over a valid/ready handshake with an optional timeout.
module rr_req_arbiter4 #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       gnt_ready,
  output logic [3:0] gnt_out,
  output logic       gnt_valid,
  output logic [3:0] pending,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pending;
  logic [3:0]       r_gnt;
  logic             r_valid;
  logic             r_timeout;

  logic [1:0]       w_cand [4];
  logic             w_found;
  logic [1:0]       w_sel;
  logic             w_hs;
  logic [3:0]       w_clr;

  // Candidate k is the (k+1)-th source after the last served one, wrapping mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi] = r_ptr + 2'(gi + 1);
    end
  endgenerate

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (r_pending[w_cand[k]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[k];
      end
    end
  end

  assign w_hs  = r_valid & gnt_ready;
  assign w_clr = w_hs ? r_gnt : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd3;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_pending <= 4'b0000;
      r_gnt     <= 4'b0000;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // A new request on the bit being served in this cycle keeps it pending.
      r_pending <= (r_pending & ~w_clr) | req_in;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= 4'b0001 << w_sel;
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_hs) begin
            r_ptr   <= r_idx;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (r_cnt == LP_CNT_LAST)) begin
            r_ptr     <= r_idx;
            r_gnt     <= 4'b0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_out   = r_gnt;
  assign gnt_valid = r_valid;
  assign pending   = r_pending;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_req_arbiter4.sv
// Directed bench for rr_req_arbiter4: each task drives one scenario and checks
// outputs one cycle at a time against hand-computed values.
module tb_rr_req_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       gnt_ready;
  logic [3:0] gnt_out;
  logic       gnt_valid;
  logic [3:0] pending;
  logic       timeout;

  int total;
  int bad;

  rr_req_arbiter4 #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .gnt_ready (gnt_ready),
    .gnt_out   (gnt_out),
    .gnt_valid (gnt_valid),
    .pending   (pending),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_in    = 4'b0000;
    gnt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (gnt_out !== 4'b0000 || gnt_valid !== 1'b0 || pending !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset: gnt_out=%b gnt_valid=%b pending=%b timeout=%b, want 0000 0 0000 0",
               gnt_out, gnt_valid, pending, timeout);
    end
    $display("test_reset: gnt_out=%b gnt_valid=%b pending=%b timeout=%b", gnt_out, gnt_valid, pending, timeout);
  endtask

  task automatic test_single();
    do_reset();
    req_in    = 4'b0100;
    gnt_ready = 1'b1;
    tick();
    req_in = 4'b0000;
    total++;
    if (pending !== 4'b0100 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_latch: pending=%b valid=%b, want 0100 0", pending, gnt_valid);
    end
    tick();
    total++;
    if (gnt_out !== 4'b0100 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt_out=%b valid=%b, want 0100 1", gnt_out, gnt_valid);
    end
    tick();
    total++;
    if (gnt_out !== 4'b0000 || gnt_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL single_done: gnt_out=%b valid=%b pending=%b, want 0000 0 0000", gnt_out, gnt_valid, pending);
    end
    $display("test_single: grant 0100 issued and served, pending=%b", pending);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt [4];
    logic [3:0] exp_pend [4];
    exp_gnt[0]  = 4'b0001; exp_gnt[1]  = 4'b0010; exp_gnt[2]  = 4'b0100; exp_gnt[3]  = 4'b1000;
    exp_pend[0] = 4'b1111; exp_pend[1] = 4'b1110; exp_pend[2] = 4'b1100; exp_pend[3] = 4'b1000;
    do_reset();
    req_in    = 4'b1111;
    gnt_ready = 1'b1;
    tick();
    req_in = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (gnt_valid !== 1'b0 || pending !== exp_pend[k]) begin
        bad++;
        $display("FAIL b2b_bubble%0d: valid=%b pending=%b, want 0 %b", k, gnt_valid, pending, exp_pend[k]);
      end
      tick();
      total++;
      if (gnt_out !== exp_gnt[k] || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_grant%0d: gnt_out=%b valid=%b, want %b 1", k, gnt_out, gnt_valid, exp_gnt[k]);
      end
      $display("test_back_to_back: grant %0d gnt_out=%b", k, gnt_out);
      tick();
    end
    total++;
    if (pending !== 4'b0000 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: pending=%b valid=%b, want 0000 0", pending, gnt_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_in    = 4'b0110;
    gnt_ready = 1'b0;
    tick();
    req_in = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (gnt_out !== 4'b0010 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_hold%0d: gnt_out=%b valid=%b timeout=%b, want 0010 1 0", i, gnt_out, gnt_valid, timeout);
      end
    end
    tick();
    total++;
    if (timeout !== 1'b1 || gnt_valid !== 1'b0 || gnt_out !== 4'b0000 || pending !== 4'b0110) begin
      bad++;
      $display("FAIL timeout_pulse: timeout=%b valid=%b gnt_out=%b pending=%b, want 1 0 0000 0110",
               timeout, gnt_valid, gnt_out, pending);
    end
    tick();
    total++;
    if (timeout !== 1'b0 || gnt_out !== 4'b0100 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next: timeout=%b gnt_out=%b valid=%b, want 0 0100 1", timeout, gnt_out, gnt_valid);
    end
    $display("test_timeout: withdrawn 0010, next grant gnt_out=%b", gnt_out);
  endtask

  task automatic test_set_wins();
    do_reset();
    req_in    = 4'b0101;
    gnt_ready = 1'b1;
    tick();
    req_in = 4'b0000;
    tick();
    total++;
    if (gnt_out !== 4'b0001 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL setwin_grant0: gnt_out=%b valid=%b, want 0001 1", gnt_out, gnt_valid);
    end
    req_in = 4'b0001;
    tick();
    req_in = 4'b0000;
    total++;
    if (pending !== 4'b0101 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL setwin_pending: pending=%b valid=%b, want 0101 0", pending, gnt_valid);
    end
    tick();
    total++;
    if (gnt_out !== 4'b0100 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL setwin_other: gnt_out=%b valid=%b, want 0100 1", gnt_out, gnt_valid);
    end
    tick();
    tick();
    total++;
    if (gnt_out !== 4'b0001 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL setwin_regrant: gnt_out=%b valid=%b, want 0001 1", gnt_out, gnt_valid);
    end
    tick();
    total++;
    if (pending !== 4'b0000 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL setwin_end: pending=%b valid=%b, want 0000 0", pending, gnt_valid);
    end
    $display("test_set_wins: source 0 regranted, pending=%b", pending);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    // Serve source 1 first so the pointer moves away from its reset value.
    req_in    = 4'b0010;
    gnt_ready = 1'b1;
    tick();
    req_in = 4'b0000;
    tick();
    tick();
    gnt_ready = 1'b0;
    req_in    = 4'b1010;
    tick();
    req_in = 4'b0000;
    tick();
    total++;
    if (gnt_out !== 4'b1000 || gnt_valid !== 1'b1 || pending !== 4'b1010) begin
      bad++;
      $display("FAIL rstmid_pre: gnt_out=%b valid=%b pending=%b, want 1000 1 1010", gnt_out, gnt_valid, pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (gnt_valid !== 1'b0 || gnt_out !== 4'b0000 || pending !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_drop: valid=%b gnt_out=%b pending=%b timeout=%b, want 0 0000 0000 0",
               gnt_valid, gnt_out, pending, timeout);
    end
    // Pointer back at 3: with 1010 pending, source 1 must win over source 3.
    req_in = 4'b1010;
    tick();
    req_in = 4'b0000;
    tick();
    total++;
    if (gnt_out !== 4'b0010 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ptr: gnt_out=%b valid=%b, want 0010 1", gnt_out, gnt_valid);
    end
    $display("test_reset_mid_grant: after reset gnt_out=%b", gnt_out);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_in    = 4'b0000;
    gnt_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_set_wins();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
